// File: rtl/otter_pipe_pkg.sv
// Purpose: shared Otter pipeline widths, register-zero constant and ID/EX register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package otter_pipe_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int PCW  = 32;

    // x0 is hardwired to zero and never participates in bypass or hazards
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    // Contents of the ID/EX pipeline register handed to EX
    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [AW-1:0]   rd;
        logic            reg_write;
        logic            is_load;
    } id_ex_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Purpose: bundles decode-side, register-file, bypass and EX-side signals of the operand stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs on the decode and EX sides.
interface operand_fetch_stage_if #(
    parameter int XLEN = otter_pipe_pkg::XLEN,
    parameter int AW   = otter_pipe_pkg::AW,
    parameter int PCW  = otter_pipe_pkg::PCW
);
    // decode side
    logic            in_valid;
    logic            in_ready;
    logic [PCW-1:0]  in_pc;
    logic [AW-1:0]   in_rs1_adr;
    logic [AW-1:0]   in_rs2_adr;
    logic [AW-1:0]   in_rd;
    logic            in_reg_write;
    logic            in_is_load;
    // register file read port
    logic [AW-1:0]   rf_adr1;
    logic [AW-1:0]   rf_adr2;
    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    // EX bypass
    logic            ex_valid;
    logic [AW-1:0]   ex_rd;
    logic            ex_reg_write;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_result;
    // MEM bypass
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    // EX side
    logic            out_valid;
    logic            out_ready;
    logic [PCW-1:0]  out_pc;
    logic [XLEN-1:0] out_rs1;
    logic [XLEN-1:0] out_rs2;
    logic [AW-1:0]   out_rd;
    logic            out_reg_write;
    logic            out_is_load;

    // the operand stage itself
    modport slave (
        input  in_valid, in_pc, in_rs1_adr, in_rs2_adr, in_rd, in_reg_write, in_is_load,
        input  rf_rs1, rf_rs2,
        input  ex_valid, ex_rd, ex_reg_write, ex_is_load, ex_result,
        input  mem_valid, mem_rd, mem_reg_write, mem_result,
        input  out_ready,
        output in_ready, rf_adr1, rf_adr2,
        output out_valid, out_pc, out_rs1, out_rs2, out_rd, out_reg_write, out_is_load
    );

    // the surrounding pipeline (decode, register file, EX, MEM)
    modport master (
        output in_valid, in_pc, in_rs1_adr, in_rs2_adr, in_rd, in_reg_write, in_is_load,
        output rf_rs1, rf_rs2,
        output ex_valid, ex_rd, ex_reg_write, ex_is_load, ex_result,
        output mem_valid, mem_rd, mem_reg_write, mem_result,
        output out_ready,
        input  in_ready, rf_adr1, rf_adr2,
        input  out_valid, out_pc, out_rs1, out_rs2, out_rd, out_reg_write, out_is_load
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Purpose: priority operand select for one source: x0, EX bypass, MEM bypass, register file.
// Latency: combinational.
// Backpressure: none; the caller decides when the value is captured.
module operand_fwd_mux #(
    parameter int XLEN = otter_pipe_pkg::XLEN,
    parameter int AW   = otter_pipe_pkg::AW
) (
    input  logic [AW-1:0]   s,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_valid,
    input  logic            ex_reg_write,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] operand
);
    import otter_pipe_pkg::*;

    // A load in EX has no data yet, so it is never a bypass source; the stall
    // logic in the parent holds the consumer until the load reaches MEM.
    always_comb begin
        operand = rf_data;
        if (s == REG_ZERO) begin
            operand = '0;
        end else if (ex_valid && ex_reg_write && !ex_is_load && (ex_rd == s)) begin
            operand = ex_result;
        end else if (mem_valid && mem_reg_write && (mem_rd == s)) begin
            operand = mem_result;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Purpose: ID/EX operand stage: reads the register file, bypasses EX/MEM results, stalls on load-use.
// Latency: 1 cycle from acceptance to out_valid; flush squashes the register on the next edge.
// Backpressure: in_ready drops while the output register is held (out_ready=0) or on a load-use hazard.
// Optional: define OPERAND_STALL_CNT_EN to add a saturating load-use stall counter (stall_count/stall_count_clr).
module operand_fetch_stage #(
    parameter int XLEN = otter_pipe_pkg::XLEN,
    parameter int AW   = otter_pipe_pkg::AW,
    parameter int PCW  = otter_pipe_pkg::PCW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    operand_fetch_stage_if.slave bus
`ifdef OPERAND_STALL_CNT_EN
    ,
    input  logic                 stall_count_clr,
    output logic [31:0]          stall_count
`endif
);
    import otter_pipe_pkg::*;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [PCW-1:0]  cap_pc;
    logic            ex_load_hit;
    logic            stall;
    logic            load_en;
    logic            xfer;
    logic            out_valid_q;
    id_ex_t          out_q;
    id_ex_t          nxt;

    // register file is addressed straight from decode so data returns this cycle
    assign bus.rf_adr1 = bus.in_rs1_adr;
    assign bus.rf_adr2 = bus.in_rs2_adr;

    operand_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs1 (
        .s             (bus.in_rs1_adr),
        .rf_data       (bus.rf_rs1),
        .ex_valid      (bus.ex_valid),
        .ex_reg_write  (bus.ex_reg_write),
        .ex_is_load    (bus.ex_is_load),
        .ex_rd         (bus.ex_rd),
        .ex_result     (bus.ex_result),
        .mem_valid     (bus.mem_valid),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .mem_result    (bus.mem_result),
        .operand       (op1)
    );

    operand_fwd_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs2 (
        .s             (bus.in_rs2_adr),
        .rf_data       (bus.rf_rs2),
        .ex_valid      (bus.ex_valid),
        .ex_reg_write  (bus.ex_reg_write),
        .ex_is_load    (bus.ex_is_load),
        .ex_rd         (bus.ex_rd),
        .ex_result     (bus.ex_result),
        .mem_valid     (bus.mem_valid),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .mem_result    (bus.mem_result),
        .operand       (op2)
    );

    // Load in EX targeting either source: checked against rs2 even when the
    // instruction ignores it, which costs an occasional needless bubble.
    assign ex_load_hit = bus.ex_valid & bus.ex_reg_write & bus.ex_is_load &
                         (bus.ex_rd != REG_ZERO) &
                         ((bus.ex_rd == bus.in_rs1_adr) | (bus.ex_rd == bus.in_rs2_adr));
    assign stall   = bus.in_valid & ex_load_hit;

    // Flush overrides both backpressure and stall so the squashed instruction
    // is drained from decode instead of lingering.
    assign load_en      = !out_valid_q | bus.out_ready;
    assign bus.in_ready = flush | (load_en & !stall);
    assign xfer         = bus.in_valid & bus.in_ready & !flush;

    assign cap_pc = bus.in_pc;

    // next contents of the ID/EX register
    always_comb begin
        nxt           = '0;
        nxt.pc        = cap_pc;
        nxt.rs1       = op1;
        nxt.rs2       = op2;
        nxt.rd        = bus.in_rd;
        nxt.reg_write = bus.in_reg_write;
        nxt.is_load   = bus.in_is_load;
    end

    // ID/EX register: flush kills, otherwise load or bubble when EX can take it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_en) begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_q <= nxt;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_q.pc;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.out_is_load   = out_q.is_load;

`ifdef OPERAND_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // count load-use bubbles that were not overridden by a flush; clear wins, saturate at max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_count_clr) begin
            stall_cnt_q <= '0;
        end else if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Purpose: directed scoreboard bench for operand_fetch_stage (bypass priority, load-use, backpressure, flush, reset).
// Latency: expects each accepted instruction on out_* one cycle after acceptance.
// Backpressure: drives out_ready low to hold the output register and checks in_ready.
module tb_operand_fetch_stage;
    import otter_pipe_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
`ifdef OPERAND_STALL_CNT_EN
    logic        stall_count_clr = 1'b0;
    logic [31:0] stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    id_ex_t exp_q[$];

    operand_fetch_stage_if #(.XLEN(32), .AW(5), .PCW(32)) bus ();

    operand_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef OPERAND_STALL_CNT_EN
        ,
        .stall_count_clr (stall_count_clr),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_reg_write = 0; bus.ex_is_load = 0; bus.ex_result = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic rw, input logic ld);
        bus.in_pc = pc; bus.in_rs1_adr = a1; bus.in_rs2_adr = a2;
        bus.in_rd = rd; bus.in_reg_write = rw; bus.in_is_load = ld;
    endtask

    // present one instruction, wait for in_ready, queue the expected register contents
    task automatic send(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic rw, input logic ld,
                        input logic [31:0] e1, input logic [31:0] e2);
        id_ex_t e;
        bit done = 0;
        drive(pc, a1, a2, rd, rw, ld);
        bus.in_valid = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e = '{pc: pc, rs1: e1, rs2: e2, rd: rd, reg_write: rw, is_load: ld};
                exp_q.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: pc 0x%0h never accepted", pc);
        end
        tick();
        bus.in_valid = 0;
    endtask

    // monitor: every retirement into EX is checked against the scoreboard head
    initial begin
        id_ex_t act;
        id_ex_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
                act = '{pc: bus.out_pc, rs1: bus.out_rs1, rs2: bus.out_rs2, rd: bus.out_rd,
                        reg_write: bus.out_reg_write, is_load: bus.out_is_load};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got pc 0x%0h with empty scoreboard", act.pc);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL out_pc_0x%0h: got rs1 0x%0h rs2 0x%0h rd %0d rw %0b ld %0b expected pc 0x%0h rs1 0x%0h rs2 0x%0h rd %0d rw %0b ld %0b",
                                 act.pc, act.rs1, act.rs2, act.rd, act.reg_write, act.is_load,
                                 e.pc, e.rs1, e.rs2, e.rd, e.reg_write, e.is_load);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.out_ready = 1;
        drive(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.rf_rs1 = 0; bus.rf_rs2 = 0;
        clear_bypass();

        // reset values
        #1 rst_n = 0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_rs1", bus.out_rs1, 0);
        check("rst_out_rd", bus.out_rd, 0);
`ifdef OPERAND_STALL_CNT_EN
        check("rst_stall_count", stall_count, 0);
`endif
        tick();
        rst_n = 1;
        tick();

        // plain register file read
        bus.rf_rs1 = 32'h11; bus.rf_rs2 = 32'h22;
        send(32'h100, 5'd3, 5'd4, 5'd1, 1, 0, 32'h11, 32'h22);

        // bypass priority: EX beats MEM, MEM when EX does not write, x0 always zero
        bus.ex_valid = 1; bus.ex_rd = 5; bus.ex_reg_write = 1; bus.ex_result = 32'hAAAA;
        bus.mem_valid = 1; bus.mem_rd = 5; bus.mem_reg_write = 1; bus.mem_result = 32'hBBBB;
        send(32'h104, 5'd5, 5'd4, 5'd2, 1, 0, 32'hAAAA, 32'h22);
        bus.ex_reg_write = 0;
        send(32'h108, 5'd5, 5'd4, 5'd2, 1, 0, 32'hBBBB, 32'h22);
        bus.ex_reg_write = 1; bus.ex_rd = 0; bus.mem_rd = 0;
        send(32'h10C, 5'd0, 5'd0, 5'd2, 1, 0, 32'h0, 32'h0);
        bus.ex_rd = 5; bus.mem_rd = 6;
        send(32'h110, 5'd5, 5'd6, 5'd3, 0, 1, 32'hAAAA, 32'hBBBB);
        bus.ex_is_load = 0; bus.ex_rd = 9;
        send(32'h114, 5'd5, 5'd6, 5'd3, 1, 0, 32'h11, 32'hBBBB);

        // load-use: one bubble, then the load data arrives from MEM
        clear_bypass();
        bus.ex_valid = 1; bus.ex_rd = 7; bus.ex_reg_write = 1; bus.ex_is_load = 1; bus.ex_result = 32'hDEAD;
        bus.rf_rs1 = 32'h55; bus.rf_rs2 = 32'h99;
        drive(32'h300, 5'd2, 5'd7, 5'd8, 1, 0);
        bus.in_valid = 1;
        @(negedge clk);
        check("loaduse_in_ready_stall", bus.in_ready, 0);
        tick();
        bus.ex_valid = 0; bus.ex_is_load = 0;
        bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_reg_write = 1; bus.mem_result = 32'h1234;
        @(negedge clk);
        check("loaduse_bubble", bus.out_valid, 0);
        check("loaduse_in_ready_resume", bus.in_ready, 1);
        exp_q.push_back('{pc: 32'h300, rs1: 32'h55, rs2: 32'h1234, rd: 5'd8, reg_write: 1'b1, is_load: 1'b0});
        tick();
        bus.in_valid = 0;
        tick();
        tick();

        // backpressure: held output, new instruction waits
        clear_bypass();
        bus.rf_rs1 = 32'h11; bus.rf_rs2 = 32'h22;
        bus.out_ready = 0;
        send(32'h400, 5'd3, 5'd4, 5'd1, 1, 0, 32'h11, 32'h22);
        bus.rf_rs1 = 32'h77;
        drive(32'h404, 5'd9, 5'd4, 5'd10, 1, 0);
        bus.in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_pc_hold", bus.out_pc, 32'h400);
            check("bp_out_rs1_hold", bus.out_rs1, 32'h11);
            tick();
        end
        bus.out_ready = 1;
        send(32'h404, 5'd9, 5'd4, 5'd10, 1, 0, 32'h77, 32'h22);
        bus.out_ready = 0;

        // flush with a held instruction, incoming instruction and active stall
        bus.ex_valid = 1; bus.ex_rd = 7; bus.ex_reg_write = 1; bus.ex_is_load = 1;
        drive(32'h500, 5'd7, 5'd1, 5'd11, 1, 0);
        bus.in_valid = 1;
        flush = 1;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 1);
        tick();
        flush = 0; bus.in_valid = 0;
        clear_bypass();
        void'(exp_q.pop_back());
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_no_capture", bus.out_pc, 32'h404);
        tick();

        // asynchronous reset while an instruction is held
        send(32'h600, 5'd3, 5'd4, 5'd1, 1, 0, 32'h77, 32'h22);
        #2 rst_n = 0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_pc", bus.out_pc, 0);
        void'(exp_q.pop_back());
        tick();
        rst_n = 1;
        bus.out_ready = 1;
        tick();

`ifdef OPERAND_STALL_CNT_EN
        // four counted stalls, one stall masked by flush, then clear during a stall
        @(negedge clk);
        check("cnt_after_reset", stall_count, 0);
        tick();
        bus.ex_valid = 1; bus.ex_rd = 7; bus.ex_reg_write = 1; bus.ex_is_load = 1;
        drive(32'h700, 5'd1, 5'd7, 5'd12, 1, 0);
        bus.in_valid = 1;
        for (int i = 0; i < 4; i++) tick();
        flush = 1;
        tick();
        flush = 0; bus.in_valid = 0;
        @(negedge clk);
        check("cnt_four_stalls", stall_count, 4);
        tick();
        bus.in_valid = 1; stall_count_clr = 1;
        tick();
        bus.in_valid = 0; stall_count_clr = 0;
        @(negedge clk);
        check("cnt_clr_priority", stall_count, 0);
        tick();
        clear_bypass();
`endif

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID/EX operand stage of the pipelined Otter core.
- Drives the register file read addresses and captures the two source operands.
- Resolves RAW hazards by forwarding from the EX and MEM stages, and stalls one cycle on load-use.
- Holds the result in a valid/ready pipeline register that feeds EX.

Parameters:
XLEN, 32, operand/result data width
AW, 5, register address width (32 architectural registers)
PCW, 32, program counter width

Ports:
clk  in  1  pipeline clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  branch/exception squash; discards in-flight and incoming instruction
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts the decoded instruction this cycle
in_pc  in  PCW  instruction PC
in_rs1_adr  in  AW  source 1 register index
in_rs2_adr  in  AW  source 2 register index
in_rd  in  AW  destination register index
in_reg_write  in  1  instruction writes rd
in_is_load  in  1  instruction is a load
rf_adr1  out  AW  register file read address 1 (= in_rs1_adr, combinational)
rf_adr2  out  AW  register file read address 2 (= in_rs2_adr, combinational)
rf_rs1  in  XLEN  register file read data 1 (combinational, x0 reads 0)
rf_rs2  in  XLEN  register file read data 2
ex_valid, ex_rd, ex_reg_write, ex_is_load, ex_result  in  1/AW/1/1/XLEN  instruction in EX and its ALU result this cycle
mem_valid, mem_rd, mem_reg_write, mem_result  in  1/AW/1/XLEN  instruction in MEM and its final result (load data included)
out_valid  out  1  operand register valid
out_ready  in  1  EX accepts the operand register
out_pc, out_rs1, out_rs2, out_rd, out_reg_write, out_is_load  out  PCW/XLEN/XLEN/AW/1/1  registered operands and control

Behaviour:
- Reset (async, rst_n=0): out_valid=0; every other out_* is 0.
- Register update: `load_en = !out_valid | out_ready`.
- Accept condition: `in_ready = load_en & !stall`. Transfer occurs when `in_valid & in_ready`.
- On transfer, the out_* registers capture next posedge. Latency is 1 cycle from acceptance to out_valid.
- If load_en is true and there is no transfer, out_valid clears to 0 (bubble).
- If load_en is false, all out_* hold.
- Operand select, evaluated per source s (rs1, rs2) in priority order:
  1. s==0 gives 0.
  2. `ex_valid & ex_reg_write & !ex_is_load & ex_rd==s` gives ex_result.
  3. `mem_valid & mem_reg_write & mem_rd==s` gives mem_result.
  4. Otherwise rf_rsN.
- WB needs no forwarding path: the register file writes on negedge, so a same-cycle WB write is visible to the combinational read.
- Load-use stall: `stall = in_valid & ex_valid & ex_reg_write & ex_is_load & ex_rd!=0 & (ex_rd==in_rs1_adr | ex_rd==in_rs2_adr)`.
  - During a stall, in_ready=0 and a bubble is inserted.
  - Next cycle the load is in MEM and the operand comes from mem_result.
- Stall is evaluated regardless of whether the instruction actually uses rs2. This is a conservative false stall and is allowed.
- Flush (synchronous, highest priority):
  - out_valid clears next posedge.
  - in_ready=1 that cycle, so any incoming instruction is consumed and dropped.
  - stall is ignored.
- Simultaneous flush and out_ready: flush wins and out_valid=0.
- Reset mid-operation clears state immediately. No partial transfer survives.

Optional Feature:
- Macro: OPERAND_STALL_CNT_EN.
- Defined:
  - Adds output stall_count (32 bits), reset to 0.
  - Increments each cycle `stall & !flush`, saturating at 0xFFFFFFFF.
  - Adds input stall_count_clr (1 bit), a synchronous clear that takes priority over increment.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package otter_pipe_pkg:
  - XLEN/AW defaults
  - typedef id_ex_t struct (pc, rs1, rs2, rd, reg_write, is_load)
  - constant REG_ZERO = 5'd0
- Sub-module operand_fwd_mux: pure combinational priority select for one source.
  - Inputs: s, rf data, ex/mem bypass fields.
  - Instantiated twice.
- Top level holds the stall logic, the pipeline register and the optional counter.

Test Plan:
1. Reset then plain read: rst_n low→high, rf_rs1=0x11, rf_rs2=0x22, in_rs1=3, in_rs2=4, no bypass, out_ready=1 → next cycle out_valid=1, out_rs1=0x11, out_rs2=0x22.
2. Priority: ex (rd=5, result 0xAAAA) and mem (rd=5, result 0xBBBB) both hit, in_rs1=5 → out_rs1=0xAAAA. With ex_reg_write=0 → 0xBBBB. With in_rs1=0 and all hits at rd=0 → 0.
3. Load-use: ex_is_load=1, ex_rd=7, in_rs2=7 → in_ready=0 one cycle, out_valid=0 bubble. Next cycle mem_rd=7, mem_result=0x1234 → accepted, out_rs2=0x1234.
4. Backpressure: out_valid=1, out_ready=0 for 3 cycles, new in_valid → in_ready=0, out_* stable. out_ready=1 → held instruction retires and new one loads next cycle.
5. Flush: flush=1 with out_valid=1, in_valid=1, stall active → in_ready=1, out_valid=0 next cycle, no data captured.
6. OPERAND_STALL_CNT_EN: 4 load-use stalls and one stall coincident with flush → stall_count=4. stall_count_clr asserted together with a stall → 0.
